// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Optional madd/maddu accumulate is enabled with MDU_MADD_EN.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MADDU = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: maps op/operands/HI/LO to a new {hi,lo}.
// With MDU_MADD_EN defined, ops 6/7 accumulate into {hi,lo}.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        we
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        na;
  logic        nb;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // One unsigned divider serves both div and divu via magnitude/sign fixup
  assign na  = (mdu_op == MDU_DIV) & a[31];
  assign nb  = (mdu_op == MDU_DIV) & b[31];
  assign ua  = na ? -a : a;
  assign ub  = nb ? -b : b;
  assign dvs = (ub == 32'd0) ? 32'd1 : ub;
  assign uq  = ua / dvs;
  assign ur  = ua % dvs;
  assign q   = (na ^ nb) ? -uq : uq;
  assign r   = na ? -ur : ur;

  always_comb begin
    res = {hi, lo};
    we  = 1'b0;
    case (mdu_op)
      MDU_MULT: begin
        res = prod_s;
        we  = 1'b1;
      end
      MDU_MULTU: begin
        res = prod_u;
        we  = 1'b1;
      end
      MDU_DIV, MDU_DIVU: begin
        res = {r, q};
        we  = (b != 32'd0);
      end
      MDU_MTHI: begin
        res = {a, lo};
        we  = 1'b1;
      end
      MDU_MTLO: begin
        res = {hi, a};
        we  = 1'b1;
      end
`ifdef MDU_MADD_EN
      MDU_MADD: begin
        res = {hi, lo} + prod_s;
        we  = 1'b1;
      end
      MDU_MADDU: begin
        res = {hi, lo} + prod_u;
        we  = 1'b1;
      end
`endif
      default: begin
        res = {hi, lo};
        we  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle MDU: owns HI/LO, fixed latency with busy for hazard stalls.
// Define MDU_MADD_EN to enable madd/maddu (ops 6/7).
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [63:0] pend;
  logic        pend_we;
  logic [63:0] res;
  logic        we;
  logic        is_mul;
  logic        is_div;
  logic        is_mov;

  mdu_calc u_calc (
    .mdu_op (mdu_op),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo),
    .res    (res),
    .we     (we)
  );

  always_comb begin
    is_mul = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (mdu_op == MDU_MADD) || (mdu_op == MDU_MADDU);
`endif
    is_div = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
    is_mov = (mdu_op == MDU_MTHI) || (mdu_op == MDU_MTLO);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_we <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (state == S_IDLE) begin
      if (start && is_mul) begin
        state   <= S_MULT;
        cnt     <= 16'(MULT_CYCLES);
        pend    <= res;
        pend_we <= we;
      end else if (start && is_div) begin
        state   <= S_DIV;
        cnt     <= 16'(DIV_CYCLES);
        pend    <= res;
        pend_we <= we;
      end else if (start && is_mov) begin
        {hi, lo} <= res;
      end
    end else if (cnt == 16'd1) begin
      state <= S_IDLE;
      cnt   <= '0;
      if (pend_we) begin
        {hi, lo} <= pend;
      end
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU; consumes the same rs/rt operands.
- Owns the architectural HI/LO registers and produces the mult/div results later read by mfhi/mflo.
- Presents fixed, MIPS-style multi-cycle latency and a busy flag that the hazard unit uses to stall mult/div/mfhi/mflo/mthi/mtlo.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (>=1).
- DIV_CYCLES, 10, cycles busy is held for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle request to launch mdu_op with a/b.
- mdu_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6/7 reserved (see Optional Feature).
- a  input  32  operand rs.
- b  input  32  operand rt.
- busy  output  1  high while an operation is in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high, port reset.
- Reset values: hi=0, lo=0, busy=0, state=IDLE, counter=0, pending result=0.
- FSM states:
  - IDLE: start with op 0/1 -> MULT, op 2/3 -> DIV.
  - MULT/DIV: counter counts down from MULT_CYCLES/DIV_CYCLES; at counter==1 -> IDLE.
- Operand capture: at the launching edge k, the result (64-bit product, or quotient/remainder) is computed from a/b and latched into a pending register.
  - Operands need not be held after edge k.
- Timing: busy rises after edge k and falls after edge k+N, N = MULT_CYCLES or DIV_CYCLES.
  - hi/lo take the pending value at edge k+N; hi/lo are unchanged during edges k..k+N-1.
- mult: {hi,lo} = signed a*b. multu: unsigned a*b.
- div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero (b==0, div or divu): the FSM still runs DIV_CYCLES with busy high; hi/lo are left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
- mthi/mtlo in IDLE: hi (resp. lo) = a at the same edge; busy stays 0.
- start while busy: ignored entirely, for any op. The hazard unit guarantees it never happens; the bench checks the ignore.
- Reserved op (6/7 with the feature off): ignored, no state change.
- reset asserted mid-operation: immediate abort, all outputs return to reset values, the pending result is discarded.
- Back-to-back: start may be asserted in the first cycle where busy==0 after completion; the new op launches normally.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 6 = madd, {hi,lo} += signed a*b; op 7 = maddu, {hi,lo} += unsigned a*b.
  - Both are 64-bit wrap-around accumulate.
  - The accumulate base is the hi/lo value at the launching edge.
  - Latency is MULT_CYCLES with the same busy behaviour as mult.
- Undefined: ops 6/7 are reserved and ignored; no accumulate logic is synthesised.

Decomposition:
- Shared package mdu_pkg:
  - mdu_op encodings (MDU_MULT..MDU_MADDU) as constants.
  - FSM state encoding (S_IDLE, S_MULT, S_DIV).
  - Default cycle counts.
- One natural sub-module, mdu_calc: purely combinational, maps (mdu_op, a, b, hi, lo) to a 64-bit {hi,lo} result plus a write-enable.
  - Write-enable = 0 on divide by zero and on reserved ops.
  - The top level holds the FSM, counter, pending register and HI/LO.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3 with start for one cycle: busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2: after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; hi/lo unchanged at edges 1-4.
- div a=-7 (0xFFFFFFF9), b=2: after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu a=7, b=0 with prior hi=0x11, lo=0x22: busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- mthi a=0xDEADBEEF in IDLE: hi=0xDEADBEEF next edge, busy=0. A start of mtlo during a running mult is ignored: lo ends as the product, not as a.
- Start div 100/7, assert reset at cycle 4: busy=0, hi=lo=0 immediately. A subsequent mult 6*7 gives lo=42, hi=0 after 5 cycles.
